// File: rtl/cs_window_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cs_pkg
// Description : Shared types and width helpers for the cs_window_filter
//               slice: the result-mode encoding, the exact running-sum
//               width and the smallest output width that holds a CS result.
// Revision    : 1.0 - initial release
// ============================================================================
package cs_pkg;

    // Result select captured with each sample. Code 3 is reserved and
    // produces the CS result.
    typedef enum logic [1:0] {
        CS_MODE_CS    = 2'd0,
        CS_MODE_MEAN  = 2'd1,
        CS_MODE_XAPPR = 2'd2,
        CS_MODE_RSVD  = 2'd3
    } cs_mode_e;

    // Bits needed to hold the sum of n samples of dw bits without overflow.
    function automatic int cs_sum_width(input int dw, input int n);
        return $clog2(n * ((1 << dw) - 1) + 1);
    endfunction

    // Smallest output width that holds (sum + n*xappr) >> shift exactly.
    // The worst case is sum and n*xappr both at n*(2^dw-1).
    function automatic int cs_min_ow(input int dw, input int n, input int shift);
        return $clog2(2 * n * ((1 << dw) - 1) + 1) - shift;
    endfunction

endpackage : cs_pkg
`default_nettype wire

// File: rtl/cs_window_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : cs_window_filter_if
// Description : Stream interface of the sliding-window filter.
//               master : sample source / result sink (drives in_*, flush)
//               slave  : the filter (drives out_valid, out_data, win_full)
//   in_valid  - qualifies in_data and in_mode, no backpressure
//   in_data   - unsigned sample, DW bits
//   in_mode   - result select travelling with the sample
//   flush     - synchronous clear of window and pipeline
//   out_valid - out_data carries a result this cycle
//   out_data  - result, OW bits
//   win_full  - window holds N samples
// Revision    : 1.0 - initial release
// ============================================================================
interface cs_window_filter_if #(
    parameter int DW = 8,
    parameter int OW = 10
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          flush;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          win_full;

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output flush,
        input  out_valid,
        input  out_data,
        input  win_full
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  flush,
        output out_valid,
        output out_data,
        output win_full
    );
endinterface : cs_window_filter_if
`default_nettype wire

// File: rtl/cs_window_filter_max_le_search.sv
`default_nettype none
// ============================================================================
// Module      : cs_max_le_search
// Description : Combinational search for the largest entry that does not
//               exceed a threshold. Returns 0 when no entry qualifies, which
//               matches the answer when the qualifying maximum is itself 0.
//   entries   - N packed entries of DW bits
//   threshold - upper bound (inclusive)
//   max_le    - largest entry <= threshold
// Revision    : 1.0 - initial release
// ============================================================================
module cs_max_le_search
    import cs_pkg::*;
#(
    parameter int N  = 9,
    parameter int DW = 8
) (
    input  logic [N-1:0][DW-1:0] entries,
    input  logic [DW-1:0]        threshold,
    output logic [DW-1:0]        max_le
);

    logic [DW-1:0] w_best;

    // Linear scan; N is at most 16 so the comparator chain stays shallow
    // enough for a single pipeline stage.
    always_comb begin
        w_best = '0;
        for (int i = 0; i < N; i++) begin
            if ((entries[i] <= threshold) && (entries[i] > w_best)) begin
                w_best = entries[i];
            end
        end
    end

    assign max_le = w_best;

endmodule : cs_max_le_search
`default_nettype wire

// File: rtl/cs_window_filter.sv
`default_nettype none
// ============================================================================
// Module      : cs_window_filter
// Description : Sliding-window filter over an unsigned sample stream. Keeps
//               the last N accepted samples with an exact running sum and,
//               once the window is full, emits per accepted sample either
//                 CS    : (sum + N*Xappr) >> SHIFT
//                 MEAN  : floor(sum/N)
//                 XAPPR : largest window sample <= floor(sum/N)
//               Two register stages after the window: stage 1 holds the
//               mean/Xappr search, stage 2 the CS arithmetic and mode mux.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - cs_window_filter_if slave port (stream in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3,
    parameter int OW    = 10
) (
    input  logic               clk,
    input  logic               reset,
    cs_window_filter_if.slave  bus
);

    localparam int c_SW  = cs_sum_width(DW, N);
    localparam int c_CW  = $clog2(N + 1);
    localparam int c_CSW = c_SW + 1 + $clog2(N);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((N < 2) || (N > 16)) begin : g_check_n
        $error("cs_window_filter: N must be in 2..16");
    end

    if (OW < cs_min_ow(DW, N, SHIFT)) begin : g_check_ow
        $error("cs_window_filter: OW too narrow for the CS result");
    end

    // ------------------------------------------------------------------
    // Window, running sum and fill count
    // ------------------------------------------------------------------
    logic [N-1:0][DW-1:0] r_win;
    logic [c_SW-1:0]      r_sum;
    logic [c_CW-1:0]      r_count;
    logic                 r_acc_d;
    cs_mode_e             r_mode_d;
    logic                 w_full;

    assign w_full = (r_count == c_CW'(N));

    // Unfilled slots are zero, so subtracting the oldest slot keeps the
    // sum exact from the very first sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win   <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            // Flush clears first; a sample arriving with it seeds the
            // fresh window.
            r_win <= '0;
            if (bus.in_valid) begin
                r_win[0] <= bus.in_data;
                r_sum    <= c_SW'(bus.in_data);
                r_count  <= c_CW'(1);
            end else begin
                r_sum   <= '0;
                r_count <= '0;
            end
        end else if (bus.in_valid) begin
            r_win <= {r_win[N-2:0], bus.in_data};
            r_sum <= r_sum - c_SW'(r_win[N-1]) + c_SW'(bus.in_data);
            if (!w_full) begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    // Marks that the window registers now reflect a freshly accepted
    // sample, and carries that sample's mode alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_d  <= 1'b0;
            r_mode_d <= CS_MODE_CS;
        end else begin
            r_acc_d <= bus.in_valid;
            if (bus.in_valid) begin
                r_mode_d <= cs_mode_e'(bus.in_mode);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: mean and Xappr
    // ------------------------------------------------------------------
    logic [DW-1:0]   w_mean;
    logic [DW-1:0]   w_xappr;
    logic [c_SW-1:0] r_sum_q;
    logic [DW-1:0]   r_mean_q;
    logic [DW-1:0]   r_xappr_q;
    cs_mode_e        r_mode_q;
    logic            r_v1;

    // The mean of DW-bit samples always fits in DW bits.
    assign w_mean = DW'(r_sum / c_SW'(N));

    cs_max_le_search #(
        .N  (N),
        .DW (DW)
    ) u_search (
        .entries   (r_win),
        .threshold (w_mean),
        .max_le    (w_xappr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum_q   <= '0;
            r_mean_q  <= '0;
            r_xappr_q <= '0;
            r_mode_q  <= CS_MODE_CS;
            r_v1      <= 1'b0;
        end else begin
            r_sum_q   <= r_sum;
            r_mean_q  <= w_mean;
            r_xappr_q <= w_xappr;
            r_mode_q  <= r_mode_d;
            r_v1      <= !bus.flush && r_acc_d && w_full;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: CS arithmetic, mode select, output register
    // ------------------------------------------------------------------
    logic [c_CSW-1:0] w_cs_full;
    logic [OW-1:0]    w_result;
    logic             r_out_valid;
    logic [OW-1:0]    r_out_data;

    assign w_cs_full = (c_CSW'(r_sum_q) + c_CSW'(N) * c_CSW'(r_xappr_q)) >> SHIFT;

    always_comb begin
        w_result = OW'(w_cs_full);
        case (r_mode_q)
            CS_MODE_MEAN:  w_result = OW'(r_mean_q);
            CS_MODE_XAPPR: w_result = OW'(r_xappr_q);
            default:       w_result = OW'(w_cs_full);
        endcase
    end

    // out_data only moves with a valid result so it holds between them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out_data <= w_result;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.win_full  = w_full;

endmodule : cs_window_filter
`default_nettype wire
